// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// fp32_pkg : binary32 field layout, constants and state type for layer 2
// Revision : 1.0
// ============================================================================
package fp32_pkg;

    typedef logic [31:0] fp32_t;

    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MAN_MSB  = 22;
    localparam int FP32_BIAS     = 127;

    localparam fp32_t FP32_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_QNAN = 32'h7FC0_0000;
    localparam fp32_t FP32_PINF = 32'h7F80_0000;
    localparam fp32_t FP32_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_BIAS = 2'd2
    } l2_state_t;

    // Leading-zero count of a 28-bit value; returns 28 for zero.
    function automatic logic [4:0] fp32_lzc28(input logic [27:0] v);
        logic [4:0] n;
        n = 5'd28;
        for (int k = 0; k < 28; k++) begin
            if (v[k]) n = 5'(27 - k);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_mul_add.sv
`default_nettype none
// ============================================================================
// fp32_mul_add : o_y = round(i_c + round(i_x * i_w)), binary32, RNE, FTZ
// Revision     : 1.0
// ============================================================================
module fp32_mul_add
    import fp32_pkg::*;
(
    input  fp32_t i_x,
    input  fp32_t i_w,
    input  fp32_t i_c,
    output fp32_t o_y
);

    fp32_t              w_prod;
    logic               w_msign;
    logic               w_xz, w_wz, w_xinf, w_winf, w_xnan, w_wnan;
    logic [47:0]        w_mp;
    logic [23:0]        w_mkeep;
    logic               w_mrnd, w_mstk;
    logic [24:0]        w_mround;
    logic signed [10:0] w_mexp;

    always_comb begin
        w_msign = i_x[FP32_SIGN_BIT] ^ i_w[FP32_SIGN_BIT];
        w_xz    = (i_x[FP32_EXP_MSB:FP32_EXP_LSB] == 8'd0);
        w_wz    = (i_w[FP32_EXP_MSB:FP32_EXP_LSB] == 8'd0);
        w_xinf  = (i_x[30:23] == 8'hFF) && (i_x[FP32_MAN_MSB:0] == 23'd0);
        w_winf  = (i_w[30:23] == 8'hFF) && (i_w[FP32_MAN_MSB:0] == 23'd0);
        w_xnan  = (i_x[30:23] == 8'hFF) && (i_x[FP32_MAN_MSB:0] != 23'd0);
        w_wnan  = (i_w[30:23] == 8'hFF) && (i_w[FP32_MAN_MSB:0] != 23'd0);
        w_mp    = {1'b1, i_x[22:0]} * {1'b1, i_w[22:0]};
        if (w_mp[47]) begin
            w_mkeep = w_mp[47:24];
            w_mrnd  = w_mp[23];
            w_mstk  = |w_mp[22:0];
        end else begin
            w_mkeep = w_mp[46:23];
            w_mrnd  = w_mp[22];
            w_mstk  = |w_mp[21:0];
        end
        w_mround = {1'b0, w_mkeep} + {24'd0, w_mrnd & (w_mstk | w_mkeep[0])};
        w_mexp   = $signed({3'b0, i_x[30:23]}) + $signed({3'b0, i_w[30:23]})
                 - 11'(FP32_BIAS) + $signed({10'd0, w_mp[47]}) + $signed({10'd0, w_mround[24]});

        if (w_xnan || w_wnan || (w_xinf && w_wz) || (w_winf && w_xz))
            w_prod = FP32_QNAN;
        else if (w_xinf || w_winf)
            w_prod = {w_msign, FP32_PINF[30:0]};
        else if (w_xz || w_wz)
            w_prod = {w_msign, 31'd0};
        else if (w_mexp >= 11'sd255)
            w_prod = {w_msign, FP32_PINF[30:0]};
        else if (w_mexp <= 11'sd0)
            w_prod = {w_msign, 31'd0};
        else  // on a rounding carry bits [23:1] are all zero
            w_prod = {w_msign, w_mexp[7:0], w_mround[24] ? w_mround[23:1] : w_mround[22:0]};
    end

    logic               w_az, w_bz, w_ainf, w_binf, w_anan, w_bnan;
    logic               w_swap, w_sub;
    fp32_t              w_big, w_sml;
    logic [7:0]         w_d;
    logic [26:0]        w_bmant, w_smant, w_ssh, w_mask;
    logic [27:0]        w_sum, w_norm;
    logic [4:0]         w_lz;
    logic [23:0]        w_akeep;
    logic               w_arnd, w_astk;
    logic [24:0]        w_around;
    logic signed [10:0] w_aexp;

    // Mantissas carry guard/round/sticky bits; the smaller operand is aligned with sticky.
    always_comb begin
        w_az   = (w_prod[30:23] == 8'd0);
        w_bz   = (i_c[30:23] == 8'd0);
        w_ainf = (w_prod[30:23] == 8'hFF) && (w_prod[22:0] == 23'd0);
        w_binf = (i_c[30:23] == 8'hFF) && (i_c[22:0] == 23'd0);
        w_anan = (w_prod[30:23] == 8'hFF) && (w_prod[22:0] != 23'd0);
        w_bnan = (i_c[30:23] == 8'hFF) && (i_c[22:0] != 23'd0);
        w_swap  = (i_c[30:0] > w_prod[30:0]);
        w_big   = w_swap ? i_c : w_prod;
        w_sml   = w_swap ? w_prod : i_c;
        w_d     = w_big[30:23] - w_sml[30:23];
        w_bmant = {1'b1, w_big[22:0], 3'b000};
        w_smant = {1'b1, w_sml[22:0], 3'b000};
        w_mask  = 27'd0;
        w_ssh   = 27'd1;
        if (w_d < 8'd27) begin
            w_mask = (27'd1 << w_d) - 27'd1;
            w_ssh  = (w_smant >> w_d) | {26'd0, |(w_smant & w_mask)};
        end
        w_sub    = w_big[31] ^ w_sml[31];
        w_sum    = w_sub ? ({1'b0, w_bmant} - {1'b0, w_ssh}) : ({1'b0, w_bmant} + {1'b0, w_ssh});
        w_lz     = fp32_lzc28(w_sum);
        w_norm   = w_sum << w_lz;
        w_akeep  = w_norm[27:4];
        w_arnd   = w_norm[3];
        w_astk   = |w_norm[2:0];
        w_around = {1'b0, w_akeep} + {24'd0, w_arnd & (w_astk | w_akeep[0])};
        w_aexp   = $signed({3'b0, w_big[30:23]}) + 11'sd1 - $signed({6'd0, w_lz})
                 + $signed({10'd0, w_around[24]});

        if (w_anan || w_bnan || (w_ainf && w_binf && (w_prod[31] ^ i_c[31])))
            o_y = FP32_QNAN;
        else if (w_ainf)
            o_y = {w_prod[31], FP32_PINF[30:0]};
        else if (w_binf)
            o_y = {i_c[31], FP32_PINF[30:0]};
        else if (w_az && w_bz)
            o_y = {w_prod[31] & i_c[31], 31'd0};
        else if (w_az)
            o_y = i_c;
        else if (w_bz)
            o_y = w_prod;
        else if (w_sum == 28'd0)
            o_y = FP32_ZERO;
        else if (w_aexp >= 11'sd255)
            o_y = {w_big[31], FP32_PINF[30:0]};
        else if (w_aexp <= 11'sd0)
            o_y = {w_big[31], 31'd0};
        else
            o_y = {w_big[31], w_aexp[7:0], w_around[24] ? w_around[23:1] : w_around[22:0]};
    end

endmodule
`default_nettype wire

// File: rtl/single_predict_layer2.sv
`default_nettype none
// ============================================================================
// single_predict_layer2 : y[j] = sum_i l[i]*W2[i][j] + b2[j], binary32 logits
// Revision              : 1.0
// ============================================================================
module single_predict_layer2
    import fp32_pkg::*;
#(
    parameter int LAYER2_NEURONS = 50,
    parameter int OUTPUT_NODES   = 10
)(
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  fp32_t l  [LAYER2_NEURONS],
    input  fp32_t W2 [LAYER2_NEURONS][OUTPUT_NODES],
    input  fp32_t b2 [OUTPUT_NODES],
    output logic  done,
    output fp32_t y  [OUTPUT_NODES]
);

    localparam int IDX_W = (LAYER2_NEURONS > 1) ? $clog2(LAYER2_NEURONS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(LAYER2_NEURONS - 1);

    l2_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_done;
    fp32_t            r_acc [OUTPUT_NODES];
    fp32_t            r_y   [OUTPUT_NODES];
    fp32_t            w_sum [OUTPUT_NODES];
    fp32_t            w_x;
    logic             w_clr, w_acc_en, w_bias_en;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // A start coinciding with the done pulse is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_acc_en    = 1'b0;
        w_bias_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !r_done) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                w_acc_en = 1'b1;
                if (r_idx == c_last_idx) w_state_nxt = ST_BIAS;
            end
            ST_BIAS: begin
                w_bias_en   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The bias pass reuses the MAC with a unit multiplier.
    assign w_x = (r_state == ST_BIAS) ? FP32_ONE : l[r_idx];

    generate
        for (genvar j = 0; j < OUTPUT_NODES; j++) begin : g_node
            fp32_t w_wgt;
            assign w_wgt = (r_state == ST_BIAS) ? b2[j] : W2[r_idx][j];
            fp32_mul_add u_mac (
                .i_x (w_x),
                .i_w (w_wgt),
                .i_c (r_acc[j]),
                .o_y (w_sum[j])
            );
            assign y[j] = r_y[j];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_done <= 1'b0;
            for (int j = 0; j < OUTPUT_NODES; j++) begin
                r_acc[j] <= FP32_ZERO;
                r_y[j]   <= FP32_ZERO;
            end
        end else begin
            r_done <= w_bias_en;
            if (w_clr) begin
                r_idx <= '0;
                for (int j = 0; j < OUTPUT_NODES; j++) r_acc[j] <= FP32_ZERO;
            end else if (w_acc_en) begin
                r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + IDX_W'(1);
                for (int j = 0; j < OUTPUT_NODES; j++) r_acc[j] <= w_sum[j];
            end
            if (w_bias_en) begin
                for (int j = 0; j < OUTPUT_NODES; j++) r_y[j] <= w_sum[j];
            end
        end
    end

    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_single_predict_layer2.sv
`default_nettype none
// ============================================================================
// tb_single_predict_layer2 : scoreboard bench with a double-precision reference
// Revision                 : 1.0
// ============================================================================
module tb_single_predict_layer2;
    import fp32_pkg::*;

    localparam int N   = 50;
    localparam int M   = 10;
    localparam int LAT = N + 2;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  start = 1'b0;
    fp32_t l  [N];
    fp32_t W2 [N][M];
    fp32_t b2 [M];
    logic  done;
    fp32_t y  [M];

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    int unsigned due_q [$];
    fp32_t       exp_vec [M];
    fp32_t       b2_tab  [M];

    single_predict_layer2 #(.LAYER2_NEURONS(N), .OUTPUT_NODES(M)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .l     (l),
        .W2    (W2),
        .b2    (b2),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // binary32 -> double, flushing subnormals and collapsing NaNs
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0)
            d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF)
            d = (f[22:0] != 23'd0) ? 64'h7FF8_0000_0000_0000 : {f[31], 11'h7FF, 52'd0};
        else
            d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // double -> binary32 with round-to-nearest-even, overflow to Inf, flush of tiny results
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [52:0] m;
        logic [24:0] k;
        logic        up;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'd0};
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e  = int'(d[62:52]) - 1023 + 127;
        m  = {1'b1, d[51:0]};
        up = m[28] && ((m[27:0] != 28'd0) || m[29]);
        k  = {1'b0, m[52:29]} + 25'(up);
        if (k[24]) begin
            e = e + 1;
            k = k >> 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], 8'(e), k[22:0]};
    endfunction

    task automatic model();
        logic [31:0] acc;
        for (int j = 0; j < M; j++) begin
            acc = 32'd0;
            for (int i = 0; i < N; i++)
                acc = r2f(f2r(acc) + f2r(r2f(f2r(l[i]) * f2r(W2[i][j]))));
            exp_vec[j] = r2f(f2r(acc) + f2r(b2[j]));
        end
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(140, 110));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Called just after a rising edge; start is sampled on the next edge.
    task automatic issue();
        for (int j = 0; j < M; j++) exp_q.push_back(exp_vec[j]);
        due_q.push_back(cyc + LAT);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 2 * LAT);
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no done pulse after %0d cycles, required one", k);
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic check_y(input string tag);
        for (int j = 0; j < M; j++) begin
            n_vec++;
            if (y[j] !== exp_vec[j]) begin
                n_err++;
                $display("FAIL %s y[%0d]: got %08h, required %08h", tag, j, y[j], exp_vec[j]);
            end
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (due_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
            end else begin
                int unsigned due;
                logic [31:0] e;
                due = due_q.pop_front();
                n_vec++;
                if (cyc != due) begin
                    n_err++;
                    $display("FAIL latency: done at cycle %0d, required %0d", cyc, due);
                end
                for (int j = 0; j < M; j++) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (y[j] !== e) begin
                        n_err++;
                        $display("FAIL result y[%0d]: got %08h, required %08h", j, y[j], e);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            l[i] = 32'd0;
            for (int j = 0; j < M; j++) W2[i][j] = 32'd0;
        end
        for (int j = 0; j < M; j++) b2[j] = 32'd0;
        b2_tab = '{32'hC000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                   32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_done: got %b, required 0", done);
        end
        for (int j = 0; j < M; j++) exp_vec[j] = 32'd0;
        check_y("reset");
        @(posedge clk); #1;

        // Ones times halves: 50 * 0.5 = 25.0
        for (int i = 0; i < N; i++) begin
            l[i] = 32'h3F80_0000;
            for (int j = 0; j < M; j++) W2[i][j] = 32'h3F00_0000;
        end
        for (int j = 0; j < M; j++) begin b2[j] = 32'd0; exp_vec[j] = 32'h41C8_0000; end
        issue();
        wait_done();
        @(posedge clk); #1;

        // Zero activations pass the bias straight through
        for (int i = 0; i < N; i++) l[i] = 32'd0;
        for (int j = 0; j < M; j++) begin b2[j] = b2_tab[j]; exp_vec[j] = b2_tab[j]; end
        issue();
        wait_done();
        @(posedge clk); #1;

        // Mixed-sign weights with a half bias
        for (int i = 0; i < N; i++) begin
            l[i] = 32'h3F80_0000;
            for (int j = 0; j < M; j++) W2[i][j] = (j == 0) ? 32'h3F80_0000 : 32'hBF80_0000;
        end
        for (int j = 0; j < M; j++) begin
            b2[j]      = 32'h3F00_0000;
            exp_vec[j] = (j == 0) ? 32'h424A_0000 : 32'hC246_0000;
        end
        issue();
        wait_done();
        @(posedge clk); #1;

        // Extra starts during ACC and in the done cycle are ignored
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++) W2[i][j] = 32'h3F00_0000;
        for (int j = 0; j < M; j++) begin b2[j] = 32'd0; exp_vec[j] = 32'h41C8_0000; end
        issue();
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (LAT + 8) @(posedge clk);
        @(negedge clk);
        check_y("no_disturb");
        @(posedge clk); #1;

        // Reset in the middle of an operation abandons it
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++) W2[i][j] = (j == 0) ? 32'h3F80_0000 : 32'hBF80_0000;
        for (int j = 0; j < M; j++) begin
            b2[j]      = 32'h3F00_0000;
            exp_vec[j] = (j == 0) ? 32'h424A_0000 : 32'hC246_0000;
        end
        issue();
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        due_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (LAT + 5) @(posedge clk);
        @(negedge clk);
        for (int j = 0; j < M; j++) exp_vec[j] = 32'd0;
        check_y("after_reset");
        @(posedge clk); #1;
        for (int j = 0; j < M; j++) exp_vec[j] = (j == 0) ? 32'h424A_0000 : 32'hC246_0000;
        issue();
        wait_done();
        @(posedge clk); #1;

        // Random normal-range operands, each started the cycle after the previous done
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                l[i] = rnd_fp();
                for (int j = 0; j < M; j++) W2[i][j] = rnd_fp();
            end
            for (int j = 0; j < M; j++) b2[j] = rnd_fp();
            model();
            issue();
            wait_done();
            @(posedge clk); #1;
        end

        repeat (5) @(posedge clk);
        n_vec++;
        if (due_q.size() != 0) begin
            n_err++;
            $display("FAIL pending: %0d results outstanding, required 0", due_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
